tluh_host_arbiter: RTL

//  Shares one TL-UH device port (e.g. a tluh_adapter_reg register slave) among NumHosts hosts.

---
 rtl/tluh_pkg.sv | 69 ++++++
 rtl/tluh_rr_arbiter.sv | 47 ++++
 rtl/tluh_host_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/tluh_pkg.sv
// -----------------------------------------------------------------------------
// tluh_pkg
//   Shared TL-UH definitions: bus geometry, A/D opcodes, the host-to-device and
//   device-to-host channel structs, and helpers that derive burst lengths from
//   an A-channel request.
//   No ports (package).
// -----------------------------------------------------------------------------
package tluh_pkg;

   localparam int unsigned TL_DW    = 32;
   localparam int unsigned TL_DBW   = TL_DW / 8;
   localparam int unsigned TL_LGDBW = $clog2(TL_DBW);
   localparam int unsigned TL_AW    = 32;
   localparam int unsigned TL_SZW   = 4;
   localparam int unsigned TL_AIW   = 8;

   typedef enum logic [2:0] {
      PutFullData    = 3'h0,
      PutPartialData = 3'h1,
      ArithmeticData = 3'h2,
      LogicalData    = 3'h3,
      Get            = 3'h4,
      Intent         = 3'h5
   } tluh_a_op_e;

   typedef enum logic [2:0] {
      AccessAck     = 3'h0,
      AccessAckData = 3'h1,
      HintAck       = 3'h2
   } tluh_d_op_e;

   typedef struct packed {
      logic              a_valid;
      tluh_a_op_e        a_opcode;
      logic [2:0]        a_param;
      logic [TL_SZW-1:0] a_size;
      logic [TL_AIW-1:0] a_source;
      logic [TL_AW-1:0]  a_address;
      logic [TL_DBW-1:0] a_mask;
      logic [TL_DW-1:0]  a_data;
      logic              d_ready;
   } tluh_h2d_t;

   typedef struct packed {
      logic              d_valid;
      tluh_d_op_e        d_opcode;
      logic [2:0]        d_param;
      logic [TL_SZW-1:0] d_size;
      logic [TL_AIW-1:0] d_source;
      logic              d_error;
      logic [TL_DW-1:0]  d_data;
      logic              a_ready;
   } tluh_d2h_t;

   // Number of data beats needed to move 2**size bytes over the data bus.
   function automatic int unsigned tluh_beats(input logic [TL_SZW-1:0] size);
      if (32'(size) <= TL_LGDBW) return 1;
      return (32'd1 << size) / TL_DBW;
   endfunction

   function automatic logic tluh_a_has_data(input tluh_a_op_e op);
      return op inside {PutFullData, PutPartialData, ArithmeticData, LogicalData};
   endfunction

   function automatic logic tluh_d_has_data(input tluh_a_op_e op);
      return op inside {Get, ArithmeticData, LogicalData};
   endfunction

endpackage

// File: rtl/tluh_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tluh_rr_arbiter
//   Combinational request selector. Picks the first requester searching upward
//   from rr_ptr_i (mod NumHosts). With TLUH_ARB_FIXED_PRIO_EN defined the
//   pointer input is removed and the lowest requesting index always wins.
// Ports
//   req_i     in   NumHosts  request vector
//   rr_ptr_i  in   IdxW      search start (round-robin build only)
//   gnt_o     out  NumHosts  one-hot winner
//   idx_o     out  IdxW      winner index
//   valid_o   out  1         some request present
// -----------------------------------------------------------------------------
module tluh_rr_arbiter #(
   parameter  int unsigned NumHosts = 4,
   localparam int unsigned IdxW     = $clog2(NumHosts)
) (
   input  logic [NumHosts-1:0] req_i,
`ifndef TLUH_ARB_FIXED_PRIO_EN
   input  logic [IdxW-1:0]     rr_ptr_i,
`endif
   output logic [NumHosts-1:0] gnt_o,
   output logic [IdxW-1:0]     idx_o,
   output logic                valid_o
);

   always_comb begin
      logic [IdxW-1:0] j;
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      j       = '0;
      for (int unsigned i = 0; i < NumHosts; i++) begin
`ifdef TLUH_ARB_FIXED_PRIO_EN
         j = IdxW'(i);
`else
         if (32'(rr_ptr_i) + i >= NumHosts) j = IdxW'(32'(rr_ptr_i) + i - NumHosts);
         else                               j = IdxW'(32'(rr_ptr_i) + i);
`endif
         if (!valid_o && req_i[j]) begin
            valid_o  = 1'b1;
            idx_o    = j;
            gnt_o[j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tluh_host_arbiter.sv
// -----------------------------------------------------------------------------
// tluh_host_arbiter
//   Shares one TL-UH device port among NumHosts hosts. A grant is held for a
//   whole transaction (all A beats and all D beats); only one transaction is
//   outstanding at the device. Round-robin by default; define
//   TLUH_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
// Ports
//   clk_i    in   1                      clock
//   rst_ni   in   1                      async active-low reset
//   tl_h_i   in   tluh_h2d_t[NumHosts]   host requests
//   tl_h_o   out  tluh_d2h_t[NumHosts]   host responses
//   tl_d_o   out  tluh_h2d_t             request to device
//   tl_d_i   in   tluh_d2h_t             response from device
//   gnt_o    out  NumHosts               one-hot current owner (0 when idle)
// -----------------------------------------------------------------------------
module tluh_host_arbiter
   import tluh_pkg::*;
#(
   parameter int unsigned NumHosts = 4,
   parameter int unsigned BeatW    = 8
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  tluh_h2d_t           tl_h_i [NumHosts],
   output tluh_d2h_t           tl_h_o [NumHosts],
   output tluh_h2d_t           tl_d_o,
   input  tluh_d2h_t           tl_d_i,
   output logic [NumHosts-1:0] gnt_o
);

   localparam int unsigned IdxW = $clog2(NumHosts);

   typedef enum logic {IDLE, BUSY} arb_state_t;

   arb_state_t          state_q, state_d;
   logic [IdxW-1:0]     gnt_idx_q, gnt_idx_d;
   logic [BeatW-1:0]    a_left_q, a_left_d;
   logic [BeatW-1:0]    d_left_q, d_left_d;
`ifndef TLUH_ARB_FIXED_PRIO_EN
   logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
`endif

   logic [NumHosts-1:0] req;
   logic [NumHosts-1:0] arb_gnt;
   logic [IdxW-1:0]     arb_idx;
   logic                arb_valid;
   logic                a_ack, d_ack;
   int unsigned         req_beats;

   always_comb begin
      for (int unsigned i = 0; i < NumHosts; i++) req[i] = tl_h_i[i].a_valid;
   end

   tluh_rr_arbiter #(
      .NumHosts (NumHosts)
   ) u_rr_arbiter (
      .req_i    (req),
`ifndef TLUH_ARB_FIXED_PRIO_EN
      .rr_ptr_i (rr_ptr_q),
`endif
      .gnt_o    (arb_gnt),
      .idx_o    (arb_idx),
      .valid_o  (arb_valid)
   );

   assign req_beats = tluh_beats(tl_h_i[arb_idx].a_size);

   // Channel routing and handshakes.
   always_comb begin
      tl_d_o = '0;
      gnt_o  = '0;
      for (int unsigned i = 0; i < NumHosts; i++) tl_h_o[i] = '0;
      unique case (state_q)
         IDLE: begin
            if (arb_valid) begin
               tl_d_o         = tl_h_i[arb_idx];
               tl_d_o.d_ready = 1'b0;
            end
            for (int unsigned i = 0; i < NumHosts; i++)
               tl_h_o[i].a_ready = arb_gnt[i] & tl_d_i.a_ready;
         end
         BUSY: begin
            gnt_o[gnt_idx_q]          = 1'b1;
            tl_d_o                    = tl_h_i[gnt_idx_q];
            tl_d_o.a_valid            = tl_h_i[gnt_idx_q].a_valid && (a_left_q != '0);
            tl_h_o[gnt_idx_q]         = tl_d_i;
            tl_h_o[gnt_idx_q].a_ready = tl_d_i.a_ready && (a_left_q != '0);
         end
      endcase
      a_ack = tl_d_o.a_valid & tl_d_i.a_ready;
      d_ack = tl_d_o.d_ready & tl_d_i.d_valid;
   end

   // Next state. Release is judged on the post-update counters so that the
   // last A beat and the last D beat may complete in either order or together.
   always_comb begin
      state_d   = state_q;
      gnt_idx_d = gnt_idx_q;
      a_left_d  = a_left_q;
      d_left_d  = d_left_q;
`ifndef TLUH_ARB_FIXED_PRIO_EN
      rr_ptr_d  = rr_ptr_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (a_ack) begin
               state_d   = BUSY;
               gnt_idx_d = arb_idx;
               a_left_d  = tluh_a_has_data(tl_h_i[arb_idx].a_opcode) ?
                           BeatW'(req_beats - 1) : '0;
               d_left_d  = tluh_d_has_data(tl_h_i[arb_idx].a_opcode) ?
                           BeatW'(req_beats) : BeatW'(1);
            end
         end
         BUSY: begin
            if (a_ack) a_left_d = a_left_q - BeatW'(1);
            if (d_ack && (d_left_q != '0)) d_left_d = d_left_q - BeatW'(1);
            if ((a_left_d == '0) && (d_left_d == '0)) begin
               state_d = IDLE;
`ifndef TLUH_ARB_FIXED_PRIO_EN
               rr_ptr_d = (gnt_idx_q == IdxW'(NumHosts - 1)) ? '0 : gnt_idx_q + IdxW'(1);
`endif
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         gnt_idx_q <= '0;
         a_left_q  <= '0;
         d_left_q  <= '0;
`ifndef TLUH_ARB_FIXED_PRIO_EN
         rr_ptr_q  <= '0;
`endif
      end else begin
         state_q   <= state_d;
         gnt_idx_q <= gnt_idx_d;
         a_left_q  <= a_left_d;
         d_left_q  <= d_left_d;
`ifndef TLUH_ARB_FIXED_PRIO_EN
         rr_ptr_q  <= rr_ptr_d;
`endif
      end
   end

endmodule
